// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point shift tracker:
// legal width/code pairs, the split shift code, the merge rule and exponent saturation.
package bfp_pkg;

    localparam int SHAMTBITS_W8  = 4;
    localparam int SHAMTBITS_W16 = 5;

    // Left field sized for the widest legal code so one struct serves both widths
    localparam int LEFT_BITS = SHAMTBITS_W16 - 1;

    typedef struct packed {
        logic                 right;
        logic [LEFT_BITS-1:0] left;
    } shamt_code_t;

    localparam int CODE_BITS = $bits(shamt_code_t);

    typedef enum logic {
        IDLE,
        ACCUM
    } frame_state_t;

    function automatic int legal_shamtbits(input int width);
        if (width == 8) begin
            return SHAMTBITS_W8;
        end else if (width == 16) begin
            return SHAMTBITS_W16;
        end
        return 0;
    endfunction

    // A pending right shift dominates: once any right bit is seen the headroom is meaningless
    function automatic shamt_code_t merge_codes(input shamt_code_t a, input shamt_code_t b);
        shamt_code_t m;
        m.right = a.right | b.right;
        m.left  = (a.left < b.left) ? a.left : b.left;
        if (m.right) begin
            m.left = '0;
        end
        return m;
    endfunction

    function automatic int exp_sat_add(input int acc, input int delta, input int expbits);
        int lo;
        int hi;
        int sum;
        lo  = -(1 << (expbits - 1));
        hi  = (1 << (expbits - 1)) - 1;
        sum = acc + delta;
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/shamt_min_tree.sv
// Combinational OR/MIN reduction of N shift codes as a balanced binary tree.
// N must be a power of two; used both across ports and for folding a beat into a frame.
module shamt_min_tree
    import bfp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N*CODE_BITS-1:0] codes,
    output logic [CODE_BITS-1:0]   result
);

    // Heap layout: leaves at N..2N-1, node i combines children 2i and 2i+1
    always_comb begin
        shamt_code_t nodes [2*N];
        nodes[0] = '0;
        for (int i = 0; i < N; i++) begin
            nodes[N+i] = codes[i*CODE_BITS +: CODE_BITS];
        end
        for (int i = N - 1; i >= 1; i--) begin
            nodes[i] = merge_codes(nodes[2*i], nodes[2*i+1]);
        end
        result = nodes[1];
    end

endmodule

// File: rtl/bfp_shamt_tracker.sv
// Per-beat and per-stage shift decisions for a block-floating-point FFT stream.
// Define BFP_EXP_ACC_EN to build the signed block-exponent accumulator on exp_o.
module bfp_shamt_tracker
    import bfp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PORTS     = 4,
    parameter int SHAMTBITS = 4,
    parameter int EXPBITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [PORTS*WIDTH-1:0] s_data,
    input  logic [PORTS*SHAMTBITS-1:0] s_shamt,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [PORTS*WIDTH-1:0] m_data,
    output logic [SHAMTBITS-1:0]   m_shamt,
    output logic                   frame_valid_o,
    output logic [SHAMTBITS-1:0]   frame_shamt_o,
    input  logic                   exp_clr_i,
    output logic [EXPBITS-1:0]     exp_o
);

    if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
        $error("bfp_shamt_tracker: WIDTH must be 8 or 16");
    end
    if (SHAMTBITS != legal_shamtbits(WIDTH)) begin : g_bad_shamtbits
        $error("bfp_shamt_tracker: SHAMTBITS does not match WIDTH");
    end
    if (PORTS < 2 || PORTS > 16 || (PORTS & (PORTS - 1)) != 0) begin : g_bad_ports
        $error("bfp_shamt_tracker: PORTS must be a power of two from 2 to 16");
    end

    function automatic shamt_code_t to_code(input logic [SHAMTBITS-1:0] raw);
        shamt_code_t c;
        c.right = raw[SHAMTBITS-1];
        c.left  = LEFT_BITS'(raw[SHAMTBITS-2:0]);
        return c;
    endfunction

    function automatic logic [SHAMTBITS-1:0] from_code(input shamt_code_t c);
        return {c.right, c.left[SHAMTBITS-2:0]};
    endfunction

    logic [PORTS*CODE_BITS-1:0] in_codes;
    shamt_code_t                beat_code;
    logic [SHAMTBITS-1:0]       beat_shamt;

    for (genvar p = 0; p < PORTS; p++) begin : g_code
        assign in_codes[p*CODE_BITS +: CODE_BITS] = to_code(s_shamt[p*SHAMTBITS +: SHAMTBITS]);
    end

    shamt_min_tree #(.N(PORTS)) u_beat_tree (
        .codes  (in_codes),
        .result (beat_code)
    );

    assign beat_shamt = from_code(beat_code);

    logic                   skid_valid;
    logic                   skid_last;
    logic [PORTS*WIDTH-1:0] skid_data;
    logic [SHAMTBITS-1:0]   skid_shamt;
    logic                   accept;
    logic                   pop;
    logic [1:0]             count_next;

    assign accept     = s_tvalid & s_tready;
    assign pop        = m_tvalid & m_tready;
    assign count_next = 2'(m_tvalid) + 2'(skid_valid) + 2'(accept) - 2'(pop);

    // The output register is the head entry; the skid entry only fills while the head is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s_tready   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_data     <= '0;
            m_shamt    <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_shamt <= '0;
        end else begin
            s_tready <= (count_next != 2'd2);
            if (pop || !m_tvalid) begin
                if (skid_valid) begin
                    m_tvalid   <= 1'b1;
                    m_tlast    <= skid_last;
                    m_data     <= skid_data;
                    m_shamt    <= skid_shamt;
                    skid_valid <= accept;
                    if (accept) begin
                        skid_last  <= s_tlast;
                        skid_data  <= s_data;
                        skid_shamt <= beat_shamt;
                    end
                end else begin
                    m_tvalid <= accept;
                    if (accept) begin
                        m_tlast <= s_tlast;
                        m_data  <= s_data;
                        m_shamt <= beat_shamt;
                    end
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_last  <= s_tlast;
                skid_data  <= s_data;
                skid_shamt <= beat_shamt;
            end
        end
    end

    frame_state_t         state;
    shamt_code_t          acc_code;
    shamt_code_t          out_code;
    shamt_code_t          merged_code;
    logic [SHAMTBITS-1:0] frame_decision;
    logic [SHAMTBITS-1:0] frame_shamt_q;

    assign out_code = to_code(m_shamt);

    shamt_min_tree #(.N(2)) u_frame_merge (
        .codes  ({out_code, acc_code}),
        .result (merged_code)
    );

    // Frames are folded as beats leave, so the decision is ready exactly when the tlast beat departs
    assign frame_decision = (state == ACCUM) ? from_code(merged_code) : m_shamt;
    assign frame_valid_o  = pop & m_tlast;
    assign frame_shamt_o  = frame_valid_o ? frame_decision : frame_shamt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc_code      <= '0;
            frame_shamt_q <= '0;
        end else if (pop) begin
            if (m_tlast) begin
                state         <= IDLE;
                frame_shamt_q <= frame_decision;
            end else begin
                state    <= ACCUM;
                acc_code <= (state == ACCUM) ? merged_code : out_code;
            end
        end
    end

`ifdef BFP_EXP_ACC_EN
    logic signed [EXPBITS-1:0] exp_q;
    shamt_code_t               frame_code;
    int                        frame_delta;
    int                        exp_base;

    assign frame_code = to_code(frame_decision);

    always_comb begin
        frame_delta = frame_code.right ? 1 : -int'(frame_code.left);
        exp_base    = exp_clr_i ? 0 : int'(exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else if (frame_valid_o) begin
            exp_q <= EXPBITS'(exp_sat_add(exp_base, frame_delta, EXPBITS));
        end else if (exp_clr_i) begin
            exp_q <= '0;
        end
    end

    assign exp_o = exp_q;
`else
    logic unused_exp_clr;
    assign unused_exp_clr = exp_clr_i;
    assign exp_o          = '0;
`endif

endmodule

// File: tb/tb_bfp_shamt_tracker.sv
// Directed bench for bfp_shamt_tracker: vector table for beat decisions plus
// hand-written frame, saturation, backpressure, reset and clear sequences.
`timescale 1ns/1ps
module tb_bfp_shamt_tracker;

    localparam int WIDTH     = 8;
    localparam int PORTS     = 4;
    localparam int SHAMTBITS = 4;
    localparam int EXPBITS   = 8;
`ifdef BFP_EXP_ACC_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic                       s_tvalid;
    logic                       s_tready;
    logic                       s_tlast;
    logic [PORTS*WIDTH-1:0]     s_data;
    logic [PORTS*SHAMTBITS-1:0] s_shamt;
    logic                       m_tvalid;
    logic                       m_tready;
    logic                       m_tlast;
    logic [PORTS*WIDTH-1:0]     m_data;
    logic [SHAMTBITS-1:0]       m_shamt;
    logic                       frame_valid_o;
    logic [SHAMTBITS-1:0]       frame_shamt_o;
    logic                       exp_clr_i;
    logic [EXPBITS-1:0]         exp_o;

    bfp_shamt_tracker #(
        .WIDTH(WIDTH), .PORTS(PORTS), .SHAMTBITS(SHAMTBITS), .EXPBITS(EXPBITS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_data(s_data), .s_shamt(s_shamt),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_data(m_data), .m_shamt(m_shamt),
        .frame_valid_o(frame_valid_o), .frame_shamt_o(frame_shamt_o),
        .exp_clr_i(exp_clr_i), .exp_o(exp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared = 0;
    int         mismatched = 0;
    int         frame_pulses = 0;
    logic [3:0] last_frame_shamt = 4'h0;
    int         exp_model = 0;

    always @(negedge clk) begin
        if (frame_valid_o === 1'b1) begin
            frame_pulses++;
            last_frame_shamt = frame_shamt_o;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] beatModel(input logic [15:0] s);
        logic any_right;
        int   mn;
        any_right = 1'b0;
        mn = 7;
        for (int p = 0; p < 4; p++) begin
            if (s[p*4+3]) any_right = 1'b1;
            if (int'(s[p*4 +: 3]) < mn) mn = int'(s[p*4 +: 3]);
        end
        return any_right ? 4'h8 : 4'(mn);
    endfunction

    function automatic int expStep(input int e, input logic [3:0] d);
        int n;
        if (!EXP_EN) return 0;
        n = d[3] ? e + 1 : e - int'(d[2:0]);
        if (n > 127) n = 127;
        if (n < -128) n = -128;
        return n;
    endfunction

    // Drives one beat and returns one time step after the edge that accepted it
    task automatic applyStimulus(input logic [15:0] shamt, input logic last);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_shamt  = shamt;
        s_data   = {shamt, ~shamt};
        s_tlast  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_tready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic clearExp();
        exp_clr_i = 1'b1;
        nextCycle();
        exp_clr_i = 1'b0;
        @(negedge clk);
        checkOutput("exp_clear", exp_o, 64'd0);
        exp_model = 0;
        nextCycle();
    endtask

    typedef struct {
        logic [15:0] shamt;
        logic [3:0]  beat;
    } vec_t;

    vec_t             vecs [7];
    logic [36:0]      sb [$];
    logic [36:0]      want;
    logic [15:0]      sh;
    int               r;
    int               sent;
    int               got;
    int               viol;
    int               cyc;
    int               p0;
    bit               acc;

    initial begin
        vecs[0] = '{16'h6253, 4'h2};
        vecs[1] = '{16'h3933, 4'h8};
        vecs[2] = '{16'h7777, 4'h7};
        vecs[3] = '{16'h4404, 4'h0};
        vecs[4] = '{16'h0008, 4'h8};
        vecs[5] = '{16'hFFFF, 4'h8};
        vecs[6] = '{16'h4321, 4'h1};

        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_data = '0; s_shamt = '0;
        m_tready = 1'b1; exp_clr_i = 1'b0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("rst_s_tready", s_tready, 64'd0);
        checkOutput("rst_m_tvalid", m_tvalid, 64'd0);
        checkOutput("rst_m_tlast", m_tlast, 64'd0);
        checkOutput("rst_m_data", m_data, 64'd0);
        checkOutput("rst_m_shamt", m_shamt, 64'd0);
        checkOutput("rst_frame_valid", frame_valid_o, 64'd0);
        checkOutput("rst_frame_shamt", frame_shamt_o, 64'd0);
        checkOutput("rst_exp", exp_o, 64'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_before_edge", s_tready, 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("ready_after_reset", s_tready, 64'd1);
        nextCycle();

        $display("[TB] single-beat vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].shamt, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_m_tvalid", i), m_tvalid, 64'd1);
            checkOutput($sformatf("vec%0d_m_shamt", i), m_shamt, 64'(vecs[i].beat));
            checkOutput($sformatf("vec%0d_m_data", i), m_data, 64'({vecs[i].shamt, ~vecs[i].shamt}));
            checkOutput($sformatf("vec%0d_m_tlast", i), m_tlast, 64'd1);
            checkOutput($sformatf("vec%0d_frame_valid", i), frame_valid_o, 64'd1);
            checkOutput($sformatf("vec%0d_frame_shamt", i), frame_shamt_o, 64'(vecs[i].beat));
            exp_model = expStep(exp_model, vecs[i].beat);
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("vec%0d_exp", i), $signed(exp_o), 64'(exp_model));
            checkOutput($sformatf("vec%0d_drained", i), m_tvalid, 64'd0);
            nextCycle();
        end

        $display("[TB] four-beat frame with a right shift");
        clearExp();
        p0 = frame_pulses;
        applyStimulus(16'h3933, 1'b0);
        applyStimulus(16'h1555, 1'b0);
        applyStimulus(16'h3333, 1'b0);
        applyStimulus(16'h4444, 1'b1);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("frameA_pulses", frame_pulses - p0, 64'd1);
        checkOutput("frameA_shamt", last_frame_shamt, 64'h8);
        checkOutput("frameA_exp", $signed(exp_o), EXP_EN ? 64'd1 : 64'd0);
        nextCycle();

        $display("[TB] headroom-3 frames to saturation");
        clearExp();
        p0 = frame_pulses;
        for (int f = 0; f < 43; f++) begin
            applyStimulus(16'h3456, 1'b0);
            applyStimulus(16'h7373, 1'b0);
            applyStimulus(16'h5335, 1'b0);
            applyStimulus(16'h3333, 1'b1);
            exp_model = expStep(exp_model, 4'h3);
            if (f == 0) begin
                repeat (2) nextCycle();
                @(negedge clk);
                checkOutput("frameB_pulses", frame_pulses - p0, 64'd1);
                checkOutput("frameB_shamt", last_frame_shamt, 64'h3);
                checkOutput("frameB_exp", $signed(exp_o), EXP_EN ? -64'sd3 : 64'd0);
                nextCycle();
            end
        end
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("sat_pulses", frame_pulses - p0, 64'd43);
        checkOutput("sat_exp_model", $signed(exp_o), 64'(exp_model));
        checkOutput("sat_exp", $signed(exp_o), EXP_EN ? -64'sd128 : 64'd0);
        nextCycle();

        $display("[TB] random backpressure stream");
        sent = 0; got = 0; viol = 0; cyc = 0; acc = 1'b0;
        p0 = frame_pulses;
        while (got < 1000 && cyc < 20000) begin
            nextCycle();
            cyc++;
            if (acc) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                acc      = 1'b0;
            end
            m_tready = ($urandom_range(0, 3) != 0);
            if (!s_tvalid && sent < 1000 && $urandom_range(0, 4) != 0) begin
                for (int p = 0; p < 4; p++) begin
                    r = int'($urandom_range(0, 15));
                    sh[p*4 +: 4] = (r >= 14) ? (4'h8 | 4'(r & 7)) : 4'(r & 7);
                end
                s_shamt  = sh;
                s_data   = $urandom;
                s_tlast  = (sent % 4 == 3);
                s_tvalid = 1'b1;
            end
            @(negedge clk);
            if (!s_tready && (sent - got) < 2) viol++;
            if (s_tvalid && s_tready) begin
                sb.push_back({s_data, s_tlast, beatModel(s_shamt)});
                sent++;
                acc = 1'b1;
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checkOutput("rand_spurious", 64'd1, 64'd0);
                end else begin
                    want = sb.pop_front();
                    checkOutput("rand_beat", {m_data, m_tlast, m_shamt}, 64'(want));
                end
                got++;
            end
        end
        nextCycle();
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        checkOutput("rand_count", 64'(got), 64'd1000);
        checkOutput("ready_invariant", 64'(viol), 64'd0);
        checkOutput("rand_frames", 64'(frame_pulses - p0), 64'd250);
        nextCycle();

        $display("[TB] reset in the middle of a frame");
        applyStimulus(16'h0008, 1'b0);
        applyStimulus(16'h0808, 1'b0);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_m_tvalid", m_tvalid, 64'd0);
        checkOutput("midrst_s_tready", s_tready, 64'd0);
        p0 = frame_pulses;
        nextCycle();
        rst = 1'b0;
        applyStimulus(16'h1111, 1'b1);
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("midrst_pulses", frame_pulses - p0, 64'd1);
        checkOutput("midrst_frame_shamt", last_frame_shamt, 64'h1);
        checkOutput("midrst_exp", $signed(exp_o), EXP_EN ? -64'sd1 : 64'd0);
        nextCycle();

        $display("[TB] clear coincident with a frame decision");
        applyStimulus(16'h0009, 1'b1);
        exp_clr_i = 1'b1;
        @(negedge clk);
        checkOutput("clr_frame_valid", frame_valid_o, 64'd1);
        checkOutput("clr_frame_shamt", frame_shamt_o, 64'h8);
        nextCycle();
        exp_clr_i = 1'b0;
        @(negedge clk);
        checkOutput("clr_exp", $signed(exp_o), EXP_EN ? 64'd1 : 64'd0);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bfp_shamt_tracker.md
BFP_SHAMT_TRACKER -- requirements
Module: bfp_shamt_tracker

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits; the only legal values are 8 and 16.
REQ-002 Parameter PORTS, default 4: samples per beat; legal values are powers of two from 2 to 16.
REQ-003 Parameter SHAMTBITS, default 4: shift-code width; SHAMTBITS SHALL equal 4 for WIDTH 8 and 5 for WIDTH 16, else elaboration fails with $error.
REQ-004 Parameter EXPBITS, default 8: signed block-exponent width.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 s_tvalid / s_tready / s_tlast  in/out/in  1 each  AXI-Stream slave handshake; tlast marks the last beat of an FFT stage.
REQ-008 s_data  in  PORTS*WIDTH  butterfly samples, port 0 in the LSBs.
REQ-009 s_shamt  in  PORTS*SHAMTBITS  per-port code: MSB = right-shift-needed; low SHAMTBITS-1 bits = left headroom.
REQ-010 m_tvalid / m_tready / m_tlast  out/in/out  1 each  AXI-Stream master handshake.
REQ-011 m_data  out  PORTS*WIDTH  samples forwarded unmodified.
REQ-012 m_shamt  out  SHAMTBITS  per-beat decision.
REQ-013 frame_valid_o  out  1  one-cycle pulse when a stage decision is ready.
REQ-014 frame_shamt_o  out  SHAMTBITS  stage-wide decision; held until the next pulse.
REQ-015 exp_clr_i  in  1  clears the block exponent.
REQ-016 exp_o  out  EXPBITS  signed accumulated block exponent.

Function
REQ-017 Beat decision: if any port's right bit is set, the decision SHALL be {1, 0}; otherwise {0, minimum left headroom over all PORTS}.
REQ-018 Latency SHALL be exactly 1 cycle from the s_ accept to m_tvalid, with m_data, m_tlast and m_shamt taken from the same beat.
REQ-019 A 2-entry skid buffer SHALL provide full throughput; s_tready SHALL be registered and deasserted only when both entries are full.
REQ-020 m_ outputs SHALL remain stable while m_tvalid=1 and m_tready=0; no beat is ever dropped or duplicated.
REQ-021 The frame FSM SHALL have states IDLE and ACCUM: an accept in IDLE loads the beat decision and enters ACCUM; an accept in ACCUM merges it (OR the right bits, MIN the left headroom).
REQ-022 An accepted beat with s_tlast SHALL return the FSM to IDLE, including a single-beat frame taken directly from IDLE.
REQ-023 frame_valid_o SHALL pulse in the cycle the tlast beat is accepted at the output (m_tvalid & m_tready & m_tlast), with frame_shamt_o valid in that same cycle.
REQ-024 On each frame_valid_o, exp_o SHALL add +1 if the right bit is set, else subtract the headroom, saturating at the signed EXPBITS limits.
REQ-025 If exp_clr_i and frame_valid_o coincide, exp_o SHALL equal 0 plus that frame's delta.

Reset
REQ-026 On rst: s_tready=0 (it SHALL rise in the first cycle after reset release), m_tvalid=0, m_tlast=0, m_data=0, m_shamt=0, frame_valid_o=0, frame_shamt_o=0, exp_o=0, both buffer entries empty, FSM=IDLE.
REQ-027 Reset asserted mid-frame SHALL discard the partial stage; no frame_valid_o is produced for it.

Configuration
REQ-028 Macro BFP_EXP_ACC_EN defined: exp_o and exp_clr_i behave per REQ-024 and REQ-025.
REQ-029 Macro BFP_EXP_ACC_EN undefined: the accumulator SHALL not be built, exp_o SHALL be tied to 0, and exp_clr_i SHALL be ignored.

Structure
REQ-030 Package bfp_pkg SHALL hold the legal WIDTH/SHAMTBITS pairs, a shamt code typedef with split right/left fields, and the saturating exponent-add function.
REQ-031 Sub-module shamt_min_tree SHALL hold the combinational PORTS-wide OR/MIN reduction (log2 PORTS levels); it is reused for the frame merge.

Verification
REQ-032 The bench SHALL cover the following scenarios.
- PORTS=4, codes {0x3,0x5,0x2,0x6}, no right bit -> m_shamt=0x2, one cycle after accept.
- Code 0x9 on port 2 -> m_shamt=0x8; 4-beat frame min-left 1, then 3 -> frame_shamt_o=0x8, exp_o=+1.
- Four beats, each with min headroom 3, tlast on beat 4 -> one frame_valid_o, frame_shamt_o=0x3, exp_o=-3; repeated 43 times -> exp_o saturates at -128.
- Random m_tready backpressure, 1000 beats -> output sequence identical to input, s_tready never low with only one entry full.
- rst during beat 2 of a frame, then a 1-beat tlast frame with code 0x1 -> frame_shamt_o=0x1, exp_o=-1.
- exp_clr_i coincident with a frame decision of 0x8 -> exp_o=+1; with BFP_EXP_ACC_EN undefined -> exp_o stays 0.
